// File: rtl/alu_pkg.sv
// Shared ALU definitions: default datapath width, opcode encoding and flag bundle.
package alu_pkg;

  localparam int unsigned AluWidth = 32;
  localparam int unsigned OpWidth  = 5;

  // Encodings 5'h07..5'h1F are unused and decode as NOP.
  typedef enum logic [OpWidth-1:0] {
    OpNop = 5'h00,
    OpAdd = 5'h01,
    OpSub = 5'h02,
    OpAnd = 5'h03,
    OpOr  = 5'h04,
    OpXor = 5'h05,
    OpNor = 5'h06
  } alu_op_e;

  typedef struct packed {
    logic zero;
    logic carry;
    logic overflow;
  } alu_flags_t;

  // Flag value forced while the block is held in reset.
  localparam alu_flags_t FlagsReset = '{zero: 1'b1, carry: 1'b0, overflow: 1'b0};

  // True for opcodes that go through the adder and can raise carry/overflow.
  function automatic logic is_arith(logic [OpWidth-1:0] op);
    return (op == OpAdd) || (op == OpSub);
  endfunction

endpackage

// File: rtl/alu_core.sv
// Combinational ALU datapath: result and flags for one operation.
module alu_core
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = AluWidth
) (
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  input  logic [OpWidth-1:0] op,
  output logic [WIDTH-1:0]   result,
  output alu_flags_t         flags
);

  logic             sub_sel;
  logic [WIDTH-1:0] b_eff;
  logic [WIDTH:0]   sum;
  logic             arith_ovf;

  // Shared adder: SUB is a + ~b + 1, so carry-out doubles as the no-borrow flag.
  always_comb begin
    sub_sel   = (op == OpSub);
    b_eff     = sub_sel ? ~b : b;
    sum       = {1'b0, a} + {1'b0, b_eff} + {{WIDTH{1'b0}}, sub_sel};
    // Signed overflow: adder inputs share a sign and the result sign differs.
    arith_ovf = (a[WIDTH-1] == b_eff[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
  end

  // Result select and flag generation; unknown opcodes fall through to NOP.
  always_comb begin
    result         = '0;
    flags.carry    = 1'b0;
    flags.overflow = 1'b0;
    case (op)
      OpAdd, OpSub: result = sum[WIDTH-1:0];
      OpAnd:        result = a & b;
      OpOr:         result = a | b;
      OpXor:        result = a ^ b;
      OpNor:        result = ~(a | b);
      default:      result = '0;
    endcase
    if (is_arith(op)) begin
      flags.carry    = sum[WIDTH];
      flags.overflow = arith_ovf;
    end
    flags.zero = (result == '0);
  end

endmodule

// File: rtl/alu_top.sv
// Registered ALU: one-cycle latency, a new operation accepted every clock.
module alu_top
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = AluWidth
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [WIDTH-1:0]   alu_a,
  input  logic [WIDTH-1:0]   alu_b,
  input  logic [OpWidth-1:0] alu_op,
  output logic [WIDTH-1:0]   alu_out,
  output logic               zero,
  output logic               carry,
  output logic               overflow
);

  logic [WIDTH-1:0] result_d;
  alu_flags_t       flags_d;
  logic [WIDTH-1:0] alu_out_q;
  alu_flags_t       flags_q;

  alu_core #(
    .WIDTH (WIDTH)
  ) u_core (
    .a      (alu_a),
    .b      (alu_b),
    .op     (alu_op),
    .result (result_d),
    .flags  (flags_d)
  );

  // Output and flag registers; reset clears them immediately, dropping any pending result.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      alu_out_q <= '0;
      flags_q   <= FlagsReset;
    end else begin
      alu_out_q <= result_d;
      flags_q   <= flags_d;
    end
  end

  assign alu_out  = alu_out_q;
  assign zero     = flags_q.zero;
  assign carry    = flags_q.carry;
  assign overflow = flags_q.overflow;

endmodule

// File: tb/tb_alu_top.sv
// Directed self-checking bench for alu_top with hand-computed expected values.
module tb_alu_top;

  localparam int unsigned W = 32;

  logic         clk;
  logic         rst;
  logic [W-1:0] alu_a;
  logic [W-1:0] alu_b;
  logic [4:0]   alu_op;
  logic [W-1:0] alu_out;
  logic         zero;
  logic         carry;
  logic         overflow;

  int n_vec;
  int n_err;

  alu_top #(
    .WIDTH (W)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .alu_a    (alu_a),
    .alu_b    (alu_b),
    .alu_op   (alu_op),
    .alu_out  (alu_out),
    .zero     (zero),
    .carry    (carry),
    .overflow (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic check_all(input string tag, input logic [W-1:0] e_out, input logic e_z,
                           input logic e_c, input logic e_v);
    check({tag, ".out"}, alu_out, e_out);
    check({tag, ".zero"}, {31'd0, zero}, {31'd0, e_z});
    check({tag, ".carry"}, {31'd0, carry}, {31'd0, e_c});
    check({tag, ".ovf"}, {31'd0, overflow}, {31'd0, e_v});
  endtask

  // Drive at the falling edge, check 1 time unit after the next rising edge.
  task automatic run_op(input string tag, input logic [4:0] op, input logic [W-1:0] a,
                        input logic [W-1:0] b, input logic [W-1:0] e_out, input logic e_z,
                        input logic e_c, input logic e_v);
    @(negedge clk);
    alu_op = op;
    alu_a  = a;
    alu_b  = b;
    @(posedge clk);
    #1;
    check_all(tag, e_out, e_z, e_c, e_v);
  endtask

  typedef struct {
    logic [4:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] e_out;
    logic         e_z;
    logic         e_c;
    logic         e_v;
  } vec_t;

  vec_t b2b [6];

  initial begin
    n_vec = 0;
    n_err = 0;

    // Reset with arbitrary inputs, checked before any rising edge.
    rst    = 1'b1;
    alu_op = 5'h01;
    alu_a  = $urandom;
    alu_b  = $urandom;
    #2;
    check_all("reset", 32'h0, 1'b1, 1'b0, 1'b0);
    @(negedge clk);
    rst = 1'b0;

    // Sweep a=29, b=12.
    run_op("nop",  5'h00, 32'd29, 32'd12, 32'h0,        1'b1, 1'b0, 1'b0);
    run_op("add",  5'h01, 32'd29, 32'd12, 32'd41,       1'b0, 1'b0, 1'b0);
    run_op("sub",  5'h02, 32'd29, 32'd12, 32'd17,       1'b0, 1'b1, 1'b0);
    run_op("and",  5'h03, 32'd29, 32'd12, 32'd12,       1'b0, 1'b0, 1'b0);
    run_op("or",   5'h04, 32'd29, 32'd12, 32'd29,       1'b0, 1'b0, 1'b0);
    run_op("xor",  5'h05, 32'd29, 32'd12, 32'd17,       1'b0, 1'b0, 1'b0);
    run_op("nor",  5'h06, 32'd29, 32'd12, 32'hFFFFFFE2, 1'b0, 1'b0, 1'b0);

    // Borrow, wrap and signed boundaries.
    run_op("sub_neg",  5'h02, 32'd12, 32'd29, 32'hFFFFFFEF, 1'b0, 1'b0, 1'b0);
    run_op("add_wrap", 5'h01, 32'hFFFFFFFF, 32'h1, 32'h0, 1'b1, 1'b1, 1'b0);
    run_op("add_sovf", 5'h01, 32'h7FFFFFFF, 32'h1, 32'h80000000, 1'b0, 1'b0, 1'b1);
    run_op("sub_sovf", 5'h02, 32'h80000000, 32'h1, 32'h7FFFFFFF, 1'b0, 1'b1, 1'b1);
    run_op("sub_eq",   5'h02, 32'hDEADBEEF, 32'hDEADBEEF, 32'h0, 1'b1, 1'b1, 1'b0);

    // Illegal opcodes behave as NOP.
    run_op("ill_1f", 5'h1F, 32'd5, 32'd3, 32'h0, 1'b1, 1'b0, 1'b0);
    run_op("ill_07", 5'h07, 32'hFFFFFFFF, 32'h1, 32'h0, 1'b1, 1'b0, 1'b0);

    // Mid-cycle input change must not reach the outputs before the next edge.
    run_op("hold_pre", 5'h01, 32'd100, 32'd23, 32'd123, 1'b0, 1'b0, 1'b0);
    alu_op = 5'h03;
    alu_a  = 32'h0;
    alu_b  = 32'h0;
    #2;
    check_all("hold_mid", 32'd123, 1'b0, 1'b0, 1'b0);

    // Back-to-back operations, one per cycle.
    b2b[0] = '{5'h01, 32'd1,        32'd2,        32'd3,        1'b0, 1'b0, 1'b0};
    b2b[1] = '{5'h02, 32'd5,        32'd5,        32'd0,        1'b1, 1'b1, 1'b0};
    b2b[2] = '{5'h05, 32'hF0F0F0F0, 32'hFF00FF00, 32'h0FF00FF0, 1'b0, 1'b0, 1'b0};
    b2b[3] = '{5'h06, 32'h0,        32'h0,        32'hFFFFFFFF, 1'b0, 1'b0, 1'b0};
    b2b[4] = '{5'h01, 32'h80000000, 32'h80000000, 32'h0,        1'b1, 1'b1, 1'b1};
    b2b[5] = '{5'h04, 32'h00000011, 32'h00000100, 32'h00000111, 1'b0, 1'b0, 1'b0};
    for (int i = 0; i < 6; i++) begin
      run_op($sformatf("b2b%0d", i), b2b[i].op, b2b[i].a, b2b[i].b, b2b[i].e_out,
             b2b[i].e_z, b2b[i].e_c, b2b[i].e_v);
    end

    // Reset mid-operation discards the pending result and acts without a clock edge.
    run_op("pre_rst", 5'h01, 32'h7FFFFFFF, 32'h1, 32'h80000000, 1'b0, 1'b0, 1'b1);
    @(negedge clk);
    alu_op = 5'h04;
    alu_a  = 32'h1234;
    alu_b  = 32'h0;
    #1;
    rst = 1'b1;
    #1;
    check_all("rst_async", 32'h0, 1'b1, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    check_all("rst_hold", 32'h0, 1'b1, 1'b0, 1'b0);

    // First edge after release loads the current inputs.
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    check_all("rst_release", 32'h1234, 1'b0, 1'b0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
